// File: rtl/apb_master_bridge_if.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_if
//   APB4 bus bundle between the bridge (master) and a set of NUM_SLAVES
//   peripheral slaves. Select, ready and error are one bit per slave; read
//   data is the concatenation of all slave read buses, slave i at
//   [i*DATA_W +: DATA_W].
//
//   Signals:
//     PADDR    master->slave  ADDR_W            offset within the slave region
//     PWRITE   master->slave  1                 1 = write
//     PSEL     master->slave  NUM_SLAVES        one-hot slave select
//     PENABLE  master->slave  1                 ACCESS phase marker
//     PWDATA   master->slave  DATA_W            write data
//     PSTRB    master->slave  DATA_W/8          write byte strobes
//     PRDATA   slave->master  NUM_SLAVES*DATA_W per-slave read data
//     PREADY   slave->master  NUM_SLAVES        per-slave ready
//     PSLVERR  slave->master  NUM_SLAVES        per-slave error
// ---------------------------------------------------------------------------
interface apb_master_bridge_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4
);
  logic [ADDR_W-1:0]            PADDR;
  logic                         PWRITE;
  logic [NUM_SLAVES-1:0]        PSEL;
  logic                         PENABLE;
  logic [DATA_W-1:0]            PWDATA;
  logic [DATA_W/8-1:0]          PSTRB;
  logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]        PREADY;
  logic [NUM_SLAVES-1:0]        PSLVERR;

  modport master (
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//   Turns the core's load/store requests into APB4 transactions across
//   NUM_SLAVES equally sized regions starting at BASE_ADDR. Supports wait
//   states, byte strobes, slave errors and a wait-state timeout. All outputs
//   are registered.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for transfer; decodes and launches on request
//   SETUP  | PSEL asserted, PENABLE low (one cycle)
//   ACCESS | PENABLE high, waiting for PREADY of the selected slave
//   RESP   | result captured; ready pulses on the following cycle
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-low reset
//     transfer   in   request valid (only looked at in IDLE)
//     busWe      in   1 = write
//     busAddr    in   request address
//     busWData   in   write data
//     busStrb    in   write byte enables
//     ready      out  one-cycle completion pulse
//     busRData   out  read data, valid while ready=1, else 0
//     busErr     out  error flag, valid while ready=1, else 0
//     apb        --   APB master side (see apb_master_bridge_if)
// ---------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 32,
  parameter int                NUM_SLAVES     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h1000_0000,
  parameter int                REGION_LOG2    = 12,
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                transfer,
  input  logic                busWe,
  input  logic [ADDR_W-1:0]   busAddr,
  input  logic [DATA_W-1:0]   busWData,
  input  logic [DATA_W/8-1:0] busStrb,
  output logic                ready,
  output logic [DATA_W-1:0]   busRData,
  output logic                busErr,
  apb_master_bridge_if.master apb
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Decode is done in 64 bits so the window end never wraps at the top of
  // the address space.
  localparam logic [63:0] BASE_EXT  = 64'(BASE_ADDR);
  localparam logic [63:0] LIMIT_EXT = BASE_EXT + (64'(NUM_SLAVES) << REGION_LOG2);
  localparam logic [63:0] OFF_MASK  = (64'd1 << REGION_LOG2) - 64'd1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic [DATA_W/8-1:0]   pstrb_q, pstrb_d;
  logic [IDX_W-1:0]      sel_idx_q, sel_idx_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]     resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic                  ready_q, ready_d;
  logic [DATA_W-1:0]     bus_rdata_q, bus_rdata_d;
  logic                  bus_err_q, bus_err_d;

  logic [63:0]           addr_diff;
  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic [ADDR_W-1:0]     dec_off;
  logic [NUM_SLAVES-1:0] psel_dec;

  logic                  pready_sel;
  logic                  pslverr_sel;
  logic [DATA_W-1:0]     prdata_sel;
  logic [CNT_W:0]        cnt_inc;
  logic                  timeout_hit;

  // Address decode of the incoming request.
  always_comb begin
    addr_diff = 64'(busAddr) - BASE_EXT;
    dec_hit   = (64'(busAddr) >= BASE_EXT) && (64'(busAddr) < LIMIT_EXT);
    dec_idx   = IDX_W'(addr_diff >> REGION_LOG2);
    dec_off   = ADDR_W'(addr_diff & OFF_MASK);
    psel_dec  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      psel_dec[i] = (dec_idx == IDX_W'(i));
    end
  end

  // Response mux: only the latched slave index is looked at, so other
  // slaves' PREADY/PSLVERR have no effect.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx_q == IDX_W'(i)) begin
        pready_sel  = apb.PREADY[i];
        pslverr_sel = apb.PSLVERR[i];
        prdata_sel  = apb.PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // cnt_inc is one bit wider than the counter so the compare never wraps.
  always_comb begin
    cnt_inc     = {1'b0, wait_cnt_q} + 1'b1;
    timeout_hit = (TIMEOUT_CYCLES != 0) && !pready_sel &&
                  (cnt_inc == (CNT_W+1)'(TIMEOUT_CYCLES));
  end

  // State register and all output/data flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      sel_idx_q   <= '0;
      wait_cnt_q  <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      ready_q     <= 1'b0;
      bus_rdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      sel_idx_q   <= sel_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      ready_q     <= ready_d;
      bus_rdata_q <= bus_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (transfer) state_d = dec_hit ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_sel || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    sel_idx_d   = sel_idx_q;
    wait_cnt_d  = wait_cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    ready_d     = 1'b0;
    bus_rdata_d = '0;
    bus_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          if (dec_hit) begin
            psel_d     = psel_dec;
            penable_d  = 1'b0;
            paddr_d    = dec_off;
            pwrite_d   = busWe;
            pwdata_d   = busWData;
            pstrb_d    = busWe ? busStrb : '0;
            sel_idx_d  = dec_idx;
            wait_cnt_d = '0;
          end else begin
            resp_data_d = '0;
            resp_err_d  = 1'b1;
          end
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        if (pready_sel) begin
          resp_data_d = pwrite_q ? '0 : prdata_sel;
          resp_err_d  = pslverr_sel;
          psel_d      = '0;
          penable_d   = 1'b0;
        end else begin
          wait_cnt_d = cnt_inc[CNT_W-1:0];
          if (timeout_hit) begin
            resp_data_d = '0;
            resp_err_d  = 1'b1;
            psel_d      = '0;
            penable_d   = 1'b0;
          end
        end
      end
      RESP: begin
        ready_d     = 1'b1;
        bus_rdata_d = resp_data_q;
        bus_err_d   = resp_err_q;
      end
      default: ;
    endcase
  end

  assign ready       = ready_q;
  assign busRData    = bus_rdata_q;
  assign busErr      = bus_err_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Parametrised successor to the core's simple single-cycle data-bus port: a multi-slave APB4 master that turns the core's load/store requests into APB transactions.
- Adds wait states (ready handshake), byte strobes, address decoding across NUM_SLAVES regions, slave-error reporting and a bus timeout.
- Sits between the core's data-bus port and the APB peripheral slaves.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 32, address width in bits.
- NUM_SLAVES, 4, number of APB slaves (one PSEL bit each); range 1..16.
- BASE_ADDR, 32'h1000_0000, start of the peripheral window.
- REGION_LOG2, 12, log2 of each slave's region size (4 KB by default).
- TIMEOUT_CYCLES, 255, maximum number of ACCESS cycles with PREADY low; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- transfer  in  1  core request valid.
- busWe  in  1  1 = write, 0 = read.
- busAddr  in  ADDR_W  request address.
- busWData  in  DATA_W  write data.
- busStrb  in  DATA_W/8  write byte enables.
- ready  out  1  one-cycle completion pulse.
- busRData  out  DATA_W  read data; valid while ready=1.
- busErr  out  1  error flag; valid while ready=1.
- PADDR  out  ADDR_W  APB address (offset within the region, upper bits zero).
- PWRITE  out  1  APB write.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWDATA  out  DATA_W  APB write data.
- PSTRB  out  DATA_W/8  APB strobes.
- PRDATA  in  NUM_SLAVES*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
- PREADY  in  NUM_SLAVES  per-slave ready.
- PSLVERR  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset: when rst=0 at a clock edge, the next state is IDLE and every output is 0, including a transfer in flight (PSEL and PENABLE drop on that edge).
- State machine: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- Address decode:
  - Hit when BASE_ADDR <= busAddr < BASE_ADDR + (NUM_SLAVES << REGION_LOG2).
  - Slave index = (busAddr - BASE_ADDR) >> REGION_LOG2.
  - Anything else is a decode miss.
- IDLE:
  - On transfer=1, capture busWe, busAddr, busWData and busStrb.
  - Decode hit: go to SETUP with PSEL[idx]=1, PENABLE=0, PADDR = offset, PWRITE = busWe, PWDATA = busWData.
  - PSTRB = busStrb for writes, 0 for reads.
  - Decode miss: go to RESP with busErr=1 and busRData=0; no APB activity.
- SETUP: always go to ACCESS with PENABLE=1. All other APB outputs hold.
- ACCESS:
  - Sample PREADY[idx] each cycle.
  - If 1: capture PRDATA[idx] (reads only; writes return 0) and PSLVERR[idx] into busRData/busErr, drop PSEL and PENABLE, go to RESP.
  - If 0: increment the wait counter.
  - If the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): abort, drop PSEL and PENABLE, set busErr=1 and busRData=0, go to RESP.
  - The counter clears on entry to SETUP.
- RESP:
  - ready=1 for exactly one cycle; busRData and busErr are valid in that cycle and return to 0 afterwards.
  - Next state is IDLE.
- Minimum latency, zero-wait slave: transfer sampled at edge 0, SETUP after edge 0, ACCESS after edge 1, ready=1 after edge 3.
- Requester protocol:
  - Holds transfer and all request fields stable until it sees ready=1.
  - transfer is ignored outside IDLE; captured fields never change mid-transaction.
  - A transfer still high in the cycle after ready is taken as a new request (back-to-back allowed).
- PREADY and PSLVERR from unselected slaves are ignored.
- The wait counter must be wide enough for TIMEOUT_CYCLES.

Test Plan:
- Read, zero wait: read at 0x1000_0004, slave 0, PREADY=1, PRDATA[0]=0xDEADBEEF → PSEL=0001, PADDR=0x004, PSTRB=0. After 4 edges: ready=1, busRData=0xDEADBEEF, busErr=0.
- Write, wait states: write at 0x1000_2010, strobe 4'b0011, data 0x1234_5678; slave 2 holds PREADY low 3 cycles → PSEL=0100, PADDR=0x010, PSTRB=0011. PENABLE high for 4 cycles; ready on the 7th edge; busRData=0.
- Decode miss: read at 0x2000_0000 → PSEL stays 0; ready=1 with busErr=1 two edges after request.
- Slave error: read to slave 3 with PREADY=1 and PSLVERR=1 → ready=1 with busErr=1. A following read to slave 1 with PSLVERR=0 shows busErr=0.
- Timeout: TIMEOUT_CYCLES=8, slave 1 never ready → exactly 8 ACCESS cycles, then PSEL=0; ready=1, busErr=1, busRData=0. Bridge then accepts a new request.
- Back-to-back plus reset: two reads held consecutively; second SETUP starts the edge after ready. Reset (rst=0) asserted during ACCESS → all outputs 0 next edge, state IDLE, no ready pulse.
